// File: rtl/tt_ram_loader.sv
// tt_ram_loader
// Writable truth-table store. A producer streams 2^ADDR_W entries over a
// valid/ready handshake into an internal RAM; once the load completes the
// block serves registered lookups addressed by addr_i.
//
// Optional feature macro: TT_PARITY_EN
//   When defined, each write beat carries a parity bit (wr_par_i). A beat with
//   odd overall parity sets the sticky parity_err_o flag, and a load that saw
//   an error finishes in IDLE instead of READY.
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_i         synchronous active-high reset
//   load_start_i  single-cycle request to (re)load the table
//   wr_valid_i    producer has an entry on wr_data_i
//   wr_data_i     entry written at the current load pointer
//   wr_ready_o    block accepts an entry this cycle (high for all of LOAD)
//   wr_par_i      parity bit for wr_data_i        (TT_PARITY_EN only)
//   parity_err_o  sticky parity error             (TT_PARITY_EN only)
//   busy_o        load in progress
//   loaded_o      table is complete and valid
//   addr_i        lookup address
//   data_o        registered lookup result (0 unless READY)
//   rd_valid_o    data_o holds a valid table entry
module tt_ram_loader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
`ifdef TT_PARITY_EN
    input  logic              wr_par_i,
    output logic              parity_err_o,
`endif
    output logic              busy_o,
    output logic              loaded_o,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_valid_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                parityErr_q, parityErr_d;
    logic [DATA_W-1:0]   data_q;
    logic                rdValid_q;
    logic                wrEn;
    logic                beatErr;
    logic                errNow;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Parity of the beat currently offered; tied off when the feature is absent
    // so the FSM below is identical in both builds.
`ifdef TT_PARITY_EN
    assign beatErr = ^{wr_data_i, wr_par_i};
`else
    assign beatErr = 1'b0;
`endif

    // Error seen so far including the beat being accepted now, so a bad final
    // beat also steers completion to IDLE.
    assign errNow = parityErr_q | beatErr;

    // State, load pointer and sticky parity flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            parityErr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            parityErr_q <= parityErr_d;
        end
    end

    // Next-state logic and Moore outputs. The pointer wraps to 0 only on the
    // final accept, which is exactly when the load completes.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        parityErr_d = parityErr_q;
        wrEn        = 1'b0;
        wr_ready_o  = 1'b0;
        busy_o      = 1'b0;
        loaded_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d     = LOAD;
                    ptr_d       = '0;
                    parityErr_d = 1'b0;
                end
            end
            LOAD: begin
                wr_ready_o = 1'b1;
                busy_o     = 1'b1;
                if (wr_valid_i) begin
                    wrEn  = !rst_i;
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (beatErr) begin
                        parityErr_d = 1'b1;
                    end
                    if (ptr_q == LAST_PTR) begin
                        state_d = errNow ? IDLE : READY;
                    end
                end
            end
            READY: begin
                loaded_o = 1'b1;
                if (load_start_i) begin
                    state_d     = LOAD;
                    ptr_d       = '0;
                    parityErr_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Table RAM; deliberately not reset so contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (wrEn) begin
            mem[ptr_q] <= wr_data_i;
        end
    end

    // Registered lookup: the edge that samples a reload request still sees
    // READY and therefore registers one last valid read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q    <= '0;
            rdValid_q <= 1'b0;
        end else if (state_q == READY) begin
            data_q    <= mem[addr_i];
            rdValid_q <= 1'b1;
        end else begin
            data_q    <= '0;
            rdValid_q <= 1'b0;
        end
    end

    assign data_o     = data_q;
    assign rd_valid_o = rdValid_q;
`ifdef TT_PARITY_EN
    assign parity_err_o = parityErr_q;
`endif

endmodule

// File: tb/tb_tt_ram_loader.sv
// tb_tt_ram_loader
// Directed testbench for tt_ram_loader (ADDR_W=3, DATA_W=2). Inputs are driven
// on the falling edge and outputs are sampled on the following falling edge.
// Build with TT_PARITY_EN defined to exercise the parity error path as well.
module tb_tt_ram_loader;

    logic       clk;
    logic       rst;
    logic       loadStart;
    logic       wrValid;
    logic [1:0] wrData;
    logic       wrReady;
`ifdef TT_PARITY_EN
    logic       wrPar;
    logic       parityErr;
`endif
    logic       busy;
    logic       loaded;
    logic [2:0] addr;
    logic [1:0] data;
    logic       rdValid;

    int checks = 0;
    int errors = 0;

    logic [1:0] tbl  [8];
    logic [1:0] stim [8];

    tt_ram_loader #(
        .ADDR_W(3),
        .DATA_W(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_start_i (loadStart),
        .wr_valid_i   (wrValid),
        .wr_data_i    (wrData),
        .wr_ready_o   (wrReady),
`ifdef TT_PARITY_EN
        .wr_par_i     (wrPar),
        .parity_err_o (parityErr),
`endif
        .busy_o       (busy),
        .loaded_o     (loaded),
        .addr_i       (addr),
        .data_o       (data),
        .rd_valid_o   (rdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and advance to the next one.
    task automatic applyStimulus(input logic ls, input logic v, input logic [1:0] d,
                                 input logic p);
        loadStart = ls;
        wrValid   = v;
        wrData    = d;
`ifdef TT_PARITY_EN
        wrPar     = p;
`else
        if (p) wrData = d;
`endif
        @(negedge clk);
    endtask

    // Request a load; returns on the falling edge after the request edge.
    task automatic startLoad();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        loadStart = 1'b0;
    endtask

    // Stream stim[] into the table. With gap set, an idle beat carrying
    // different data precedes each valid beat, and one idle beat also
    // re-asserts load_start, which must be ignored while loading.
    task automatic streamTable(input bit gap);
        for (int i = 0; i < 8; i++) begin
            if (gap) applyStimulus(i == 3, 1'b0, ~stim[i], 1'b0);
            applyStimulus(1'b0, 1'b1, stim[i], ^stim[i]);
            tbl[i] = stim[i];
        end
        wrValid = 1'b0;
    endtask

    // Read back every address with one-cycle latency.
    task automatic readAll(input string tag);
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            @(negedge clk);
            checkOutput({tag, "_data"}, 32'(data), 32'(tbl[a]));
            checkOutput({tag, "_rdValid"}, 32'(rdValid), 32'd1);
        end
    endtask

    initial begin
        int busyCnt;
        rst       = 1'b1;
        loadStart = 1'b0;
        wrValid   = 1'b0;
        wrData    = 2'd0;
        addr      = 3'd0;
`ifdef TT_PARITY_EN
        wrPar     = 1'b0;
`endif
        $display("[TB] starting tt_ram_loader bench");

        // Reset for two cycles: every output low.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_wrReady", 32'(wrReady), 32'd0);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_loaded",  32'(loaded),  32'd0);
        checkOutput("rst_data",    32'(data),    32'd0);
        checkOutput("rst_rdValid", 32'(rdValid), 32'd0);
`ifdef TT_PARITY_EN
        checkOutput("rst_parityErr", 32'(parityErr), 32'd0);
`endif
        rst = 1'b0;

        // wr_valid in IDLE is ignored.
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0);
        checkOutput("idle_wrReady", 32'(wrReady), 32'd0);
        checkOutput("idle_busy",    32'(busy),    32'd0);
        checkOutput("idle_loaded",  32'(loaded),  32'd0);
        wrValid = 1'b0;

        // Full load of 0,1,2,3,3,2,1,0 with wr_valid held high.
        stim = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        startLoad();
        checkOutput("start_wrReady", 32'(wrReady), 32'd1);
        busyCnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busyCnt++;
            if (i == 7) checkOutput("preLast_loaded", 32'(loaded), 32'd0);
            applyStimulus(1'b0, 1'b1, stim[i], ^stim[i]);
            tbl[i] = stim[i];
        end
        wrValid = 1'b0;
        checkOutput("full_busyCycles", 32'(busyCnt), 32'd8);
        checkOutput("full_loaded",     32'(loaded),  32'd1);
        checkOutput("full_busy",       32'(busy),    32'd0);
        readAll("full");

        // Gapped stream: only valid beats advance the pointer.
        stim = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
        startLoad();
        streamTable(1'b1);
        checkOutput("gap_loaded", 32'(loaded), 32'd1);
        readAll("gap");

        // Reload from READY: the request edge still registers a valid read.
        addr = 3'd2;
        startLoad();
        checkOutput("reload_reqRdValid", 32'(rdValid), 32'd1);
        checkOutput("reload_reqData",    32'(data),    32'(tbl[2]));
        checkOutput("reload_loaded",     32'(loaded),  32'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("reload_rdValid", 32'(rdValid), 32'd0);
        checkOutput("reload_data",    32'(data),    32'd0);
        checkOutput("reload_busy",    32'(busy),    32'd1);
        stim = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        streamTable(1'b0);
        checkOutput("reload_done", 32'(loaded), 32'd1);
        readAll("reload");

        // Reset after four accepts aborts the load.
        startLoad();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        checkOutput("abort_loaded",  32'(loaded),  32'd0);
        checkOutput("abort_busy",    32'(busy),    32'd0);
        checkOutput("abort_wrReady", 32'(wrReady), 32'd0);
        checkOutput("abort_rdValid", 32'(rdValid), 32'd0);
        stim = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd2};
        startLoad();
        streamTable(1'b0);
        checkOutput("after_abort_loaded", 32'(loaded), 32'd1);
        readAll("after_abort");

`ifdef TT_PARITY_EN
        // Bad parity on entry 5 sets the sticky flag and the load ends in IDLE.
        stim = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        startLoad();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, stim[i], (i == 5) ? 1'b0 : ^stim[i]);
            if (i == 4) checkOutput("par_cleanSoFar", 32'(parityErr), 32'd0);
            if (i == 5) checkOutput("par_errSet",     32'(parityErr), 32'd1);
        end
        wrValid = 1'b0;
        checkOutput("par_loaded",  32'(loaded),    32'd0);
        checkOutput("par_busy",    32'(busy),      32'd0);
        checkOutput("par_sticky",  32'(parityErr), 32'd1);
        startLoad();
        checkOutput("par_cleared", 32'(parityErr), 32'd0);
        checkOutput("par_restart", 32'(busy),      32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
